// File: rtl/dpram_port_arbiter.sv
// Shares one registered-read RAM port among NREQ requesters (req/gnt/rvalid).
// Define DPRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module dpram_port_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 14,
   parameter int NREQ   = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        we,
   input  logic [NREQ*ADDR_W-1:0] addr,
   input  logic [NREQ*DATA_W-1:0] wdata,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        rvalid,
   output logic [DATA_W-1:0]      rdata,
   output logic                   busy,
   output logic                   ram_cs,
   output logic                   ram_we,
   output logic [ADDR_W-1:0]      ram_addr,
   output logic [DATA_W-1:0]      ram_wdata,
   input  logic [DATA_W-1:0]      ram_q
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      CAPTURE
   } state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   rvalid_q, rvalid_d;
   logic [NREQ-1:0]   own_q, own_d;
   logic              rd_q, rd_d;
   logic              cs_q, cs_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [IW-1:0]     win;

`ifdef DPRAM_ARB_RR_EN
   logic [IW-1:0] ptr_q, ptr_d;

   // Any requester at or after the pointer beats the wrapped ones.
   always_comb begin
      win = '0;
      for (int i = NREQ-1; i >= 0; i--)
         if (req[i]) win = IW'(i);
      for (int i = NREQ-1; i >= 0; i--)
         if (req[i] && IW'(i) >= ptr_q) win = IW'(i);
   end

   always_comb begin
      ptr_d = ptr_q;
      if (state_q == IDLE && |req) begin
         if (win == IW'(NREQ-1)) ptr_d = '0;
         else                    ptr_d = win + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end
`else
   always_comb begin
      win = '0;
      for (int i = NREQ-1; i >= 0; i--)
         if (req[i]) win = IW'(i);
   end
`endif

   always_comb begin
      state_d  = state_q;
      gnt_d    = '0;
      rvalid_d = '0;
      own_d    = own_q;
      rd_d     = rd_q;
      cs_d     = 1'b0;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               state_d    = ACCESS;
               gnt_d[win] = 1'b1;
               own_d      = '0;
               own_d[win] = 1'b1;
               rd_d       = ~we[win];
               cs_d       = 1'b1;
               we_d       = we[win];
               addr_d     = addr[int'(win)*ADDR_W +: ADDR_W];
               wdata_d    = wdata[int'(win)*DATA_W +: DATA_W];
            end
         end
         ACCESS: begin
            state_d = rd_q ? CAPTURE : IDLE;
         end
         CAPTURE: begin
            state_d  = IDLE;
            rdata_d  = ram_q;
            rvalid_d = own_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         rvalid_q <= '0;
         own_q    <= '0;
         rd_q     <= 1'b0;
         cs_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         own_q    <= own_d;
         rd_q     <= rd_d;
         cs_q     <= cs_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
      end
   end

   assign gnt       = gnt_q;
   assign rvalid    = rvalid_q;
   assign rdata     = rdata_q;
   assign busy      = (state_q != IDLE);
   assign ram_cs    = cs_q;
   assign ram_we    = we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model and a RAM model.
module tb_dpram_port_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 14;
   localparam int DW   = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_v, we_v;
   logic [NREQ*AW-1:0] addr_v;
   logic [NREQ*DW-1:0] wdata_v;
   logic [NREQ-1:0]   gnt, rvalid;
   logic [DW-1:0]     rdata;
   logic              busy, ram_cs, ram_we;
   logic [AW-1:0]     ram_addr;
   logic [DW-1:0]     ram_wdata;
   logic [DW-1:0]     ram_q;

   logic              r_req [NREQ];
   logic              r_we  [NREQ];
   logic [AW-1:0]     r_addr[NREQ];
   logic [DW-1:0]     r_wd  [NREQ];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dpram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREQ(NREQ)) dut (
      .clock(clk), .reset(reset), .req(req_v), .we(we_v),
      .addr(addr_v), .wdata(wdata_v), .gnt(gnt), .rvalid(rvalid),
      .rdata(rdata), .busy(busy), .ram_cs(ram_cs), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_q(ram_q)
   );

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_v[i] = r_req[i];
         we_v[i]  = r_we[i];
         addr_v[i*AW +: AW]  = r_addr[i];
         wdata_v[i*DW +: DW] = r_wd[i];
      end
   end

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return a[7:0] ^ {a[13:8], 2'b01} ^ 8'h3C;
   endfunction

   // RAM device: registered read, unwritten locations return the preload pattern
   logic [DW-1:0] mem  [1<<AW];
   logic          seen [1<<AW];
   logic          mem_clr = 1'b0;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int a = 0; a < (1<<AW); a++) seen[a] <= 1'b0;
         ram_q <= '0;
      end else if (ram_cs) begin
         if (ram_we) begin
            mem[ram_addr]  <= ram_wdata;
            seen[ram_addr] <= 1'b1;
         end else begin
            ram_q <= seen[ram_addr] ? mem[ram_addr] : pat(ram_addr);
         end
      end
   end

   // Reference model state
   logic [DW-1:0]   ref_mem [1<<AW];
   int              m_cool, m_ptr;
   logic [NREQ-1:0] m_s0, m_s1;
   logic [DW-1:0]   m_d0, m_d1;
   logic [NREQ-1:0] e_gnt, e_rv;
   logic [DW-1:0]   e_rdata, e_wdata;
   logic            e_cs, e_we;
   logic [AW-1:0]   e_addr;
   logic            prev_cs = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int pick();
      int w;
      w = -1;
`ifdef DPRAM_ARB_RR_EN
      for (int k = 0; k < NREQ; k++)
         if (w < 0 && r_req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
`else
      for (int k = 0; k < NREQ; k++)
         if (w < 0 && r_req[k]) w = k;
`endif
      return w;
   endfunction

   // One clock edge of the transaction model: an idle port takes the
   // chosen request; a write occupies 2 cycles, a read 3.
   task automatic model_step();
      int w;
      if (reset) begin
         m_cool = 0; m_ptr = 0;
         m_s0 = '0; m_s1 = '0;
         e_gnt = '0; e_rv = '0; e_rdata = '0;
         e_cs = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
         return;
      end
      e_rv = m_s1;
      if (m_s1 != '0) e_rdata = m_d1;
      m_s1 = m_s0; m_d1 = m_d0; m_s0 = '0;
      e_gnt = '0; e_cs = 1'b0; e_we = 1'b0;
      if (m_cool > 0) begin
         m_cool--;
      end else begin
         w = pick();
         if (w >= 0) begin
            e_gnt[w] = 1'b1;
            e_cs     = 1'b1;
            e_we     = r_we[w];
            e_addr   = r_addr[w];
            e_wdata  = r_wd[w];
            if (r_we[w]) begin
               ref_mem[r_addr[w]] = r_wd[w];
               m_cool = 1;
            end else begin
               m_s0[w] = 1'b1;
               m_d0    = ref_mem[r_addr[w]];
               m_cool  = 2;
            end
            m_ptr = (w + 1) % NREQ;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("gnt",     32'(gnt),       32'(e_gnt));
      check("rvalid",  32'(rvalid),    32'(e_rv));
      check("rdata",   32'(rdata),     32'(e_rdata));
      check("busy",    32'(busy),      32'(m_cool != 0));
      check("ram_cs",  32'(ram_cs),    32'(e_cs));
      check("ram_we",  32'(ram_we),    32'(e_we));
      check("ram_addr",32'(ram_addr),  32'(e_addr));
      check("ram_wd",  32'(ram_wdata), 32'(e_wdata));
      check("cs_pair", 32'(ram_cs & prev_cs), 32'(0));
      prev_cs = ram_cs;
   endtask

   task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      r_req[i] = 1'b1; r_we[i] = w; r_addr[i] = a; r_wd[i] = d;
   endtask

   task automatic drop_all();
      for (int i = 0; i < NREQ; i++) r_req[i] = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
   endtask

   task automatic wait_gnt(input int i, input string tag);
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!gnt[i] && n < 40);
      check(tag, 32'(gnt[i]), 32'(1));
   endtask

   task automatic wait_any(output logic [NREQ-1:0] g, inout int rv_cnt);
      int n;
      n = 0;
      do begin
         cycle();
         if (rvalid != '0) rv_cnt++;
         n++;
      end while (gnt == '0 && n < 40);
      g = gnt;
   endtask

   initial begin
      logic [NREQ-1:0] g;
      int rv_cnt;
      for (int a = 0; a < (1<<AW); a++) ref_mem[a] = pat(AW'(a));
      for (int i = 0; i < NREQ; i++) begin
         r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wd[i] = '0;
      end
      reset = 1'b1;
      mem_clr = 1'b1;
      @(posedge clk);
      #1;
      mem_clr = 1'b0;

      // Reset with every requester asking
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), '0);
      do_reset();
      check("t1_gnt",    32'(gnt),    32'(0));
      check("t1_rvalid", 32'(rvalid), 32'(0));
      check("t1_cs",     32'(ram_cs), 32'(0));
      check("t1_busy",   32'(busy),   32'(0));
      check("t1_rdata",  32'(rdata),  32'(0));
      drop_all();
      cycle();

      // Single write then read
      set_req(0, 1'b1, 14'h0123, 8'hA5);
      wait_gnt(0, "t2_wgnt");
      r_req[0] = 1'b0;
      check("t2_cs",    32'(ram_cs),   32'(1));
      check("t2_we",    32'(ram_we),   32'(1));
      check("t2_addr",  32'(ram_addr), 32'(14'h0123));
      check("t2_wdata", 32'(ram_wdata),32'(8'hA5));
      cycle();
      check("t2_cs_off", 32'(ram_cs), 32'(0));
      set_req(0, 1'b0, 14'h0123, 8'h00);
      wait_gnt(0, "t2_rgnt");
      r_req[0] = 1'b0;
      cycle();
      check("t2_rv_early", 32'(rvalid), 32'(0));
      cycle();
      check("t2_rvalid", 32'(rvalid), 32'(1));
      check("t2_rdata",  32'(rdata),  32'(8'hA5));

      // Contention
      do_reset();
      rv_cnt = 0;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(16'h0040 + i*7), '0);
`ifdef DPRAM_ARB_RR_EN
      for (int k = 0; k < 6; k++) begin
         wait_any(g, rv_cnt);
         check("t4_order", 32'(g), 32'(1 << (k % NREQ)));
      end
      drop_all();
      for (int k = 0; k < 4; k++) begin
         cycle();
         if (rvalid != '0) rv_cnt++;
      end
      check("t4_rv_cnt", 32'(rv_cnt), 32'(6));
`else
      for (int k = 0; k < 4; k++) begin
         wait_any(g, rv_cnt);
         check("t3_fixed", 32'(g), 32'(1));
      end
      r_req[0] = 1'b0;
      wait_any(g, rv_cnt);
      check("t3_next", 32'(g), 32'(2));
      drop_all();
      for (int k = 0; k < 4; k++) cycle();
`endif

      // Reset during CAPTURE of a read
      do_reset();
      set_req(0, 1'b0, 14'h0200, '0);
      wait_gnt(0, "t5_gnt");
      r_req[0] = 1'b0;
      cycle();
      check("t5_busy_cap", 32'(busy), 32'(1));
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("t5_no_rv", 32'(rvalid), 32'(0));
      check("t5_idle",  32'(busy),   32'(0));
      check("t5_rdata", 32'(rdata),  32'(0));
      cycle();
      check("t5_no_rv2", 32'(rvalid), 32'(0));
      set_req(2, 1'b0, 14'h3FFF, '0);
      wait_gnt(2, "t5_gnt2");
      r_req[2] = 1'b0;
      cycle();
      cycle();
      check("t5_rv_max", 32'(rvalid), 32'(4));
      check("t5_rd_max", 32'(rdata),  32'(pat(14'h3FFF)));

      // Back-to-back writes from one requester
      set_req(1, 1'b1, 14'h0777, 8'h3C);
      wait_gnt(1, "t6_gnt_a");
      r_wd[1] = 8'hC3;
      cycle();
      check("t6_gap", 32'(gnt), 32'(0));
      cycle();
      check("t6_gnt_b", 32'(gnt), 32'(2));
      r_req[1] = 1'b0;
      for (int k = 0; k < 3; k++) cycle();

      // Random traffic with occasional resets
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom_range(299) == 0);
         cycle();
         for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] || !r_req[i]) begin
               if ($urandom_range(2) == 0)
                  set_req(i, 1'($urandom_range(1)),
                          $urandom_range(1) ? AW'($urandom_range(15))
                                            : AW'($urandom),
                          DW'($urandom));
               else
                  r_req[i] = 1'b0;
            end else if ($urandom_range(15) == 0) begin
               r_req[i] = 1'b0;
            end
         end
      end
      reset = 1'b0;
      drop_all();
      for (int k = 0; k < 4; k++) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
